fpu_issuer: RTL and testbench
=============================

# fpu_issuer

Command-side initiator for the `fpu` execution unit. Accepts floating-point operation requests on a valid/ready stream and buffers them in a small FIFO. Issues them one at a time to the FPU with a single-cycle `perm` start pulse, waits for the FPU completion strobe or a timeout, and returns each result on a valid/ready response stream in issue order. It sits between the host/decode logic and the FPU core.

## Interface
Parameters:
- `DEPTH`, 4 — command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64 — maximum cycles spent in WAIT before the block abandons the operation.

Ports:
- `clk` in 1 — single clock; all logic on the rising edge.
- `rst` in 1 — reset, synchronous, active-low.
- `cmd_valid` in 1 — request present.
- `cmd_ready` out 1 — FIFO not full.
- `cmd_a` in 32 — IEEE-754 single operand A.
- `cmd_b` in 32 — IEEE-754 single operand B.
- `cmd_op` in 2 — 00 add, 01 sub, 10 mul, 11 div.
- `fpu_perm` out 1 — one-cycle start pulse to the FPU.
- `fpu_a` out 32 — operand A to the FPU.
- `fpu_b` out 32 — operand B to the FPU.
- `fpu_op` out 2 — opcode to the FPU.
- `fpu_done` in 1 — FPU result-valid strobe.
- `fpu_out` in 32 — FPU result.
- `rsp_valid` out 1 — response present.
- `rsp_ready` in 1 — consumer accepts the response.
- `rsp_data` out 32 — result word.
- `rsp_op` out 2 — opcode of the completed command.
- `rsp_timeout` out 1 — set when the response was produced by timeout.
- `busy` out 1 — high when the FIFO is non-empty or the state is not IDLE.

## Operation
- **FIFO**
  - Push on `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`; no bypass path.
  - Push and pop in the same cycle leave the count unchanged. A push is only allowed when not full, even if a pop happens in the same cycle.
- **IDLE**
  - If the FIFO is non-empty, pop the head, register it onto `fpu_a/b/op`, and go to ISSUE.
- **ISSUE**
  - `fpu_perm` = 1 for exactly this cycle, then go to WAIT.
  - Clear the timeout counter.
- **WAIT**
  - Counter increments each cycle.
  - When `fpu_done` = 1: capture `fpu_out` into `rsp_data`, set `rsp_timeout` = 0, go to RESP.
  - Otherwise, when the counter reaches `TIMEOUT-1`: set `rsp_data` = 32'h7FC00000 (quiet NaN), set `rsp_timeout` = 1, go to RESP.
  - `fpu_done` takes priority if both occur in the same cycle.
- **RESP**
  - `rsp_valid` = 1, holding `rsp_data`, `rsp_op` and `rsp_timeout` stable.
  - On `rsp_ready`, go to IDLE.
- **Strobe qualification**: `fpu_done` is ignored outside WAIT.
- **Operand stability**: `fpu_a/b/op` stay stable from ISSUE through the end of RESP. They change only on the next pop.
- **Reset** (`rst` = 0 at an edge, in any state):
  - State becomes IDLE and the FIFO is emptied (pointers and count = 0).
  - Any in-flight result is discarded.
  - Outputs reset to: `cmd_ready` = 1, `fpu_perm` = 0, `fpu_a/b` = 0, `fpu_op` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_op` = 0, `rsp_timeout` = 0, `busy` = 0.

## Timing
- **Minimum latency**: command accepted at edge N → `fpu_perm` high in cycle N+1..N+2 (IDLE at N+1, ISSUE entered at edge N+1).
- **Done to response**: `fpu_done` sampled at edge M → `rsp_valid` high from M.
- **Back-to-back commands**: the next ISSUE starts no earlier than one IDLE cycle after the RESP handshake. One operation is outstanding at a time.
- **Outputs**: all are registered, except that `cmd_ready` and `busy` are decoded from registered state.
- **Timeout**: with `fpu_done` never asserted, `rsp_valid` rises exactly `TIMEOUT` cycles after the ISSUE cycle.

## Structure
- **Shared package `fpu_pkg`**:
  - `fpu_op_t` enum (ADD, SUB, MUL, DIV).
  - `issuer_state_t` enum (IDLE, ISSUE, WAIT, RESP).
  - `FPU_QNAN` = 32'h7FC00000.
  - Packed command struct {a, b, op}, 66 bits.
- **Sub-module `fpu_cmd_fifo`**: synchronous FIFO parameterized by `DEPTH` and width. It uses a wrap-around pointer pair plus a count, and provides full/empty flags.
- **Top level**: the FSM, timeout counter and response registers.

## Test plan
- **Single add**: push a=32'h3FC00000, b=32'h40200000, op=00. The FPU model returns 32'h40800000 three cycles after `perm`.
  - Exactly one `perm` pulse.
  - `rsp_data`=32'h40800000, `rsp_op`=00, `rsp_timeout`=0.
- **Fill FIFO**: push 5 commands with the FPU stalled.
  - `cmd_ready` drops after the 4th FIFO entry is occupied.
  - All responses return in push order.
- **Timeout**: the FPU model never asserts done.
  - `rsp_valid` rises 64 cycles after `perm`, with `rsp_data`=32'h7FC00000 and `rsp_timeout`=1.
- **Backpressure**: hold `rsp_ready`=0 for 10 cycles.
  - `rsp_*` outputs stay stable.
  - No new `perm` is issued.
  - The FIFO keeps accepting commands until full.
- **Stray done**: assert `fpu_done` while in IDLE or RESP.
  - No state change.
  - No response corruption.
- **Reset mid-WAIT**: drive `rst`=0 for one edge with 2 commands queued.
  - All outputs return to reset values.
  - `busy`=0.
  - No response is ever emitted for the flushed commands.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared types for the FPU command issuer: opcodes, issuer states, the
// buffered command record and the quiet-NaN word returned on timeout.
package fpu_pkg;

   typedef enum logic [1:0] {
      ADD = 2'b00,
      SUB = 2'b01,
      MUL = 2'b10,
      DIV = 2'b11
   } fpu_op_t;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } issuer_state_t;

   localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      fpu_op_t     op;
   } fpu_cmd_t;

endpackage

// File: rtl/fpu_cmd_fifo.sv
// Synchronous command FIFO: wrap-around read/write pointers plus an occupancy
// count. Push is ignored when full and pop when empty; head is read directly.
module fpu_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 66
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == FULL_CNT);
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_rdata   = r_mem[r_rd_ptr];

   // NOTE: storage is not reset; r_count alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // NOTE: non-blocking assignments so every register updates from pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/fpu_issuer.sv
// Command-side initiator for the FPU: buffers requests, issues one at a time
// with a one-cycle perm pulse, and returns results (or a timeout qNaN) in order.
module fpu_issuer
   import fpu_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [31:0] cmd_a,
   input  logic [31:0] cmd_b,
   input  logic [1:0]  cmd_op,
   output logic        fpu_perm,
   output logic [31:0] fpu_a,
   output logic [31:0] fpu_b,
   output logic [1:0]  fpu_op,
   input  logic        fpu_done,
   input  logic [31:0] fpu_out,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_op,
   output logic        rsp_timeout,
   output logic        busy
);

   localparam int            CW       = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   fpu_cmd_t      w_push_cmd;
   fpu_cmd_t      w_head;
   logic          w_full;
   logic          w_empty;
   logic          w_pop;

   issuer_state_t r_state;
   logic [CW-1:0] r_cnt;
   logic          r_perm;
   logic [31:0]   r_a;
   logic [31:0]   r_b;
   fpu_op_t       r_op;
   logic          r_rsp_valid;
   logic [31:0]   r_rsp_data;
   fpu_op_t       r_rsp_op;
   logic          r_rsp_timeout;

   assign w_push_cmd = fpu_cmd_t'({cmd_a, cmd_b, cmd_op});
   assign w_pop      = (r_state == IDLE) && !w_empty;

   fpu_cmd_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fpu_cmd_t))
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (cmd_valid),
      .i_wdata (w_push_cmd),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state       <= IDLE;
         r_cnt         <= '0;
         r_perm        <= 1'b0;
         r_a           <= '0;
         r_b           <= '0;
         r_op          <= ADD;
         r_rsp_valid   <= 1'b0;
         r_rsp_data    <= '0;
         r_rsp_op      <= ADD;
         r_rsp_timeout <= 1'b0;
      end else begin
         // perm is high only in the cycle spent in ISSUE
         r_perm <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_a     <= w_head.a;
                  r_b     <= w_head.b;
                  r_op    <= w_head.op;
                  r_perm  <= 1'b1;
                  r_state <= ISSUE;
               end
            end
            ISSUE: begin
               r_cnt   <= '0;
               r_state <= WAIT;
            end
            WAIT: begin
               if (fpu_done) begin
                  r_rsp_data    <= fpu_out;
                  r_rsp_timeout <= 1'b0;
                  r_rsp_op      <= r_op;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= RESP;
               end else if (r_cnt == CNT_LAST) begin
                  r_rsp_data    <= FPU_QNAN;
                  r_rsp_timeout <= 1'b1;
                  r_rsp_op      <= r_op;
                  r_rsp_valid   <= 1'b1;
                  r_state       <= RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = !w_full;
   assign busy        = !w_empty || (r_state != IDLE);
   assign fpu_perm    = r_perm;
   assign fpu_a       = r_a;
   assign fpu_b       = r_b;
   assign fpu_op      = r_op;
   assign rsp_valid   = r_rsp_valid;
   assign rsp_data    = r_rsp_data;
   assign rsp_op      = r_rsp_op;
   assign rsp_timeout = r_rsp_timeout;

endmodule

// File: tb/tb_fpu_issuer.sv
// Self-checking bench for fpu_issuer: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_fpu_issuer;

   localparam int          DEPTH     = 4;
   localparam int          TIMEOUT   = 64;
   localparam int          LAT_NEVER = 0;
   localparam logic [31:0] QNAN      = 32'h7FC0_0000;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      int          lat;
      logic [31:0] res;
   } cmd_rec_t;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  op;
      logic        to;
   } rsp_rec_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      int          lat;
      logic [31:0] res;
      logic [31:0] exp_data;
      logic        exp_to;
      int          exp_delay;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_a = '0;
   logic [31:0] cmd_b = '0;
   logic [1:0]  cmd_op = '0;
   logic        fpu_perm;
   logic [31:0] fpu_a;
   logic [31:0] fpu_b;
   logic [1:0]  fpu_op;
   logic        fpu_done;
   logic [31:0] fpu_out;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_op;
   logic        rsp_timeout;
   logic        busy;

   // FPU behavioural model and stray-strobe injection
   logic        model_done = 1'b0;
   logic [31:0] model_out  = '0;
   logic        stray      = 1'b0;
   logic [31:0] stray_out  = '0;
   int          model_cnt  = 0;
   logic [31:0] model_res  = '0;
   assign fpu_done = model_done | stray;
   assign fpu_out  = stray ? stray_out : model_out;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_perm   = 0;
   int          cur_lat  = 1;
   logic [31:0] cur_res  = '0;
   cmd_rec_t    issue_q[$];
   rsp_rec_t    exp_q[$];
   logic        op_active    = 1'b0;
   logic [65:0] op_cap       = '0;
   logic        hold_pending = 1'b0;
   logic [35:0] hold_cap     = '0;
   logic        perm_prev    = 1'b0;
   logic        rand_done    = 1'b0;
   vec_t        vecs [5];

   fpu_issuer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
      .fpu_perm(fpu_perm), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
      .fpu_done(fpu_done), .fpu_out(fpu_out),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_timeout(rsp_timeout),
      .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [65:0] act, input logic [65:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, expv);
      end
   endtask

   // A command times out when the FPU answers later than the last WAIT cycle.
   function automatic rsp_rec_t ref_rsp(input cmd_rec_t c);
      rsp_rec_t r;
      r.to   = (c.lat == LAT_NEVER) || (c.lat > TIMEOUT);
      r.data = r.to ? QNAN : c.res;
      r.op   = c.op;
      return r;
   endfunction

   always @(negedge clk) begin
      cmd_rec_t c;
      rsp_rec_t e;
      if (!rst) begin
         issue_q.delete();
         exp_q.delete();
         model_cnt    = 0;
         model_done   = 1'b0;
         op_active    = 1'b0;
         hold_pending = 1'b0;
         perm_prev    = 1'b0;
      end else begin
         model_done = 1'b0;
         if (model_cnt > 0) begin
            model_cnt--;
            if (model_cnt == 0) begin
               model_done = 1'b1;
               model_out  = model_res;
            end
         end
         if (op_active) check("operand_stable", {fpu_a, fpu_b, fpu_op}, op_cap);
         if (hold_pending)
            check("rsp_hold", 66'({rsp_valid, rsp_timeout, rsp_op, rsp_data}), 66'(hold_cap));
         if (fpu_perm) begin
            n_perm++;
            check("perm_single_cycle", 66'(perm_prev), 66'(0));
            check("perm_during_rsp", 66'(rsp_valid), 66'(0));
            if (issue_q.size() == 0) begin
               check("perm_unexpected", 66'(issue_q.size()), 66'(1));
            end else begin
               c = issue_q.pop_front();
               check("issue_operands", {fpu_a, fpu_b, fpu_op}, {c.a, c.b, c.op});
               model_cnt = c.lat;
               model_res = c.res;
            end
            op_active = 1'b1;
            op_cap    = {fpu_a, fpu_b, fpu_op};
         end
         perm_prev = fpu_perm;
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               check("rsp_unexpected", 66'(rsp_valid), 66'(0));
            end else begin
               e = exp_q.pop_front();
               check("rsp_data", 66'(rsp_data), 66'(e.data));
               check("rsp_op", 66'(rsp_op), 66'(e.op));
               check("rsp_timeout", 66'(rsp_timeout), 66'(e.to));
            end
            op_active = 1'b0;
         end
         hold_pending = rsp_valid && !rsp_ready;
         hold_cap     = {rsp_valid, rsp_timeout, rsp_op, rsp_data};
         if (cmd_valid && cmd_ready) begin
            c = '{a: cmd_a, b: cmd_b, op: cmd_op, lat: cur_lat, res: cur_res};
            issue_q.push_back(c);
            exp_q.push_back(ref_rsp(c));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                           input int lat, input logic [31:0] res);
      int n;
      n = 0;
      cmd_a = a; cmd_b = b; cmd_op = op; cur_lat = lat; cur_res = res;
      cmd_valid = 1'b1;
      @(negedge clk);
      while (!cmd_ready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) check("push_wait", 66'(cmd_ready), 66'(1));
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_perm();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!fpu_perm && n < 20);
      check("perm_seen", 66'(fpu_perm), 66'(1));
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      while (!rsp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("rsp_seen", 66'(rsp_valid), 66'(1));
   endtask

   task automatic wait_idle(input int bound);
      int n;
      n = 0;
      while (busy && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("drain_idle", 66'(busy), 66'(0));
      step();
   endtask

   task automatic check_reset_outputs();
      check("rst_cmd_ready", 66'(cmd_ready), 66'(1));
      check("rst_fpu_perm", 66'(fpu_perm), 66'(0));
      check("rst_fpu_a", 66'(fpu_a), 66'(0));
      check("rst_fpu_b", 66'(fpu_b), 66'(0));
      check("rst_fpu_op", 66'(fpu_op), 66'(0));
      check("rst_rsp_valid", 66'(rsp_valid), 66'(0));
      check("rst_rsp_data", 66'(rsp_data), 66'(0));
      check("rst_rsp_op", 66'(rsp_op), 66'(0));
      check("rst_rsp_timeout", 66'(rsp_timeout), 66'(0));
      check("rst_busy", 66'(busy), 66'(0));
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired n_checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int d;
      int n_rv;

      // Delay = negedges from the perm cycle to the first rsp_valid cycle.
      vecs[0] = '{a: 32'h3FC00000, b: 32'h40200000, op: 2'b00, lat: 3,  res: 32'h40800000,
                  exp_data: 32'h40800000, exp_to: 1'b0, exp_delay: 4};
      vecs[1] = '{a: 32'h40000000, b: 32'h3F800000, op: 2'b01, lat: 1,  res: 32'h3F800000,
                  exp_data: 32'h3F800000, exp_to: 1'b0, exp_delay: 2};
      vecs[2] = '{a: 32'h40400000, b: 32'h40000000, op: 2'b10, lat: 64, res: 32'h40C00000,
                  exp_data: 32'h40C00000, exp_to: 1'b0, exp_delay: 65};
      vecs[3] = '{a: 32'h3F800000, b: 32'h40000000, op: 2'b11, lat: 65, res: 32'h3F000000,
                  exp_data: QNAN, exp_to: 1'b1, exp_delay: 65};
      vecs[4] = '{a: 32'h00000000, b: 32'h80000000, op: 2'b00, lat: LAT_NEVER, res: 32'h0,
                  exp_data: QNAN, exp_to: 1'b1, exp_delay: 65};

      repeat (3) step();
      check_reset_outputs();
      rst = 1'b1;
      step();

      for (int i = 0; i < 5; i++) begin
         p0 = n_perm;
         push_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].lat, vecs[i].res);
         wait_perm();
         check("vec_issue", {fpu_a, fpu_b, fpu_op}, {vecs[i].a, vecs[i].b, vecs[i].op});
         d = 0;
         while (!rsp_valid && d < 200) begin
            @(negedge clk);
            d++;
         end
         check("vec_delay", 66'(d), 66'(vecs[i].exp_delay));
         check("vec_data", 66'(rsp_data), 66'(vecs[i].exp_data));
         check("vec_op", 66'(rsp_op), 66'(vecs[i].op));
         check("vec_timeout", 66'(rsp_timeout), 66'(vecs[i].exp_to));
         check("vec_busy", 66'(busy), 66'(1));
         step();
         rsp_ready = 1'b1;
         step();
         rsp_ready = 1'b0;
         check("vec_idle_busy", 66'(busy), 66'(0));
         check("vec_rsp_cleared", 66'(rsp_valid), 66'(0));
         check("vec_perm_count", 66'(n_perm - p0), 66'(1));
      end

      // Fill: FPU stalled, one command in flight plus four buffered.
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++)
         push_cmd(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 2'(i), LAT_NEVER, 32'h0);
      check("fill_ready_low", 66'(cmd_ready), 66'(0));
      @(negedge clk);
      check("fill_ready_still_low", 66'(cmd_ready), 66'(0));
      step();
      push_cmd(32'h1111_1111, 32'h2222_2222, 2'b11, 3, 32'hCAFE_F00D);
      wait_idle(1000);
      check("fill_drained", 66'(exp_q.size()), 66'(0));

      // Backpressure: response held, FIFO keeps filling, no new issue.
      rsp_ready = 1'b0;
      p0 = n_perm;
      push_cmd(32'h3F80_0000, 32'h3F80_0000, 2'b00, 2, 32'h4000_0000);
      wait_rsp();
      step();
      for (int i = 0; i < 4; i++)
         push_cmd(32'h5000_0000 + 32'(i), 32'h6000_0000, 2'b10, 2, 32'h7000_0000 + 32'(i));
      check("bp_fifo_full", 66'(cmd_ready), 66'(0));
      repeat (5) step();
      check("bp_no_perm", 66'(n_perm - p0), 66'(1));
      check("bp_rsp_valid", 66'(rsp_valid), 66'(1));
      check("bp_rsp_data", 66'(rsp_data), 66'(32'h4000_0000));
      rsp_ready = 1'b1;
      wait_idle(500);

      // Stray done in IDLE and in RESP.
      stray_out = 32'hDEAD_BEEF;
      stray = 1'b1;
      repeat (3) step();
      stray = 1'b0;
      check("stray_idle_rsp", 66'(rsp_valid), 66'(0));
      check("stray_idle_busy", 66'(busy), 66'(0));
      rsp_ready = 1'b0;
      push_cmd(32'h4040_0000, 32'h4080_0000, 2'b01, 2, 32'h1234_5678);
      wait_rsp();
      step();
      stray = 1'b1;
      repeat (3) step();
      stray = 1'b0;
      check("stray_resp_data", 66'(rsp_data), 66'(32'h1234_5678));
      check("stray_resp_to", 66'(rsp_timeout), 66'(0));
      check("stray_resp_valid", 66'(rsp_valid), 66'(1));
      rsp_ready = 1'b1;
      wait_idle(200);

      // Reset while WAITing with two commands still queued.
      p0 = n_perm;
      for (int i = 0; i < 3; i++)
         push_cmd(32'hA000_0000 + 32'(i), 32'hB000_0000, 2'b11, LAT_NEVER, 32'h0);
      repeat (10) step();
      check("rstw_busy_before", 66'(busy), 66'(1));
      rst = 1'b0;
      step();
      rst = 1'b1;
      check_reset_outputs();
      n_rv = 0;
      for (int i = 0; i < 150; i++) begin
         @(negedge clk);
         if (rsp_valid) n_rv++;
      end
      check("rstw_no_response", 66'(n_rv), 66'(0));
      check("rstw_perm_count", 66'(n_perm - p0), 66'(1));
      step();

      // Randomized traffic with random response backpressure.
      fork
         begin
            for (int k = 0; k < 300; k++) begin
               int r;
               int lat;
               r = int'($urandom_range(0, 19));
               if (r == 0)      lat = LAT_NEVER;
               else if (r == 1) lat = int'($urandom_range(60, 66));
               else             lat = int'($urandom_range(1, 12));
               push_cmd($urandom, $urandom, 2'($urandom_range(0, 3)), lat, $urandom);
               repeat ($urandom_range(0, 3)) step();
            end
            rand_done = 1'b1;
         end
         begin
            while (!rand_done) begin
               step();
               rsp_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      rsp_ready = 1'b1;
      wait_idle(5000);
      check("rand_exp_empty", 66'(exp_q.size()), 66'(0));
      check("rand_issue_empty", 66'(issue_q.size()), 66'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
